mage_hwlp_iv_gen: RTL and testbench
===================================

Name: mage_hwlp_iv_gen

Overview:
- Hardware-loop iteration-variable generator for the MAGE address generation unit.
- Walks a perfect loop nest of up to N_LP loops. Each loop is described by a loop_vars_t pair (initial value iv, final value fv).
- Emits one iteration-variable tuple per initiation interval (II) to the downstream stream/AGE address logic, using a valid/ready handshake.
- Sits between the HWLP register-file configuration path (upstream) and the AGEs (downstream).

Parameters:
- N_LP, 4, maximum number of nested loops (loop 0 is innermost).
- LOG2_N_LP, $clog2(N_LP), loop-index width.
- NBIT_LP_IV, 8, width of each iteration variable.
- NBIT_II, 4, width of the initiation-interval field.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. Asynchronous, active-low.
- cfg_we_i  in  1  latch configuration this cycle.
- cfg_loop_vars_i  in  N_LP x loop_vars_t  per-loop iv/fv.
- cfg_n_loops_i  in  LOG2_N_LP+1  number of active loops, 1..N_LP.
- cfg_ii_i  in  NBIT_II  initiation interval. 0 is treated as 1.
- start_i  in  1  begin generation (single-cycle pulse).
- stop_i  in  1  abort generation.
- iv_o  out  N_LP x NBIT_LP_IV  current iteration variables.
- iv_valid_o  out  1  iv_o is valid.
- iv_ready_i  in  1  downstream accepts iv_o.
- iv_last_o  out  1  current tuple is the final iteration (qualified by iv_valid_o).
- busy_o  out  1  FSM not in IDLE.
- done_o  out  1  one-cycle pulse after the last tuple is accepted.
- cfg_err_o  out  1  sticky: latched configuration has fv<iv in an active loop, or n_loops is 0 or greater than N_LP.

Behaviour:
- Reset (async, rst_n_i=0):
  - All outputs 0.
  - FSM to IDLE; config registers cleared; counters cleared.
- Configuration:
  - cfg_we_i is honoured only in IDLE and is ignored otherwise.
  - cfg_err_o is recomputed on each accepted write.
- FSM states: IDLE, RUN, WAIT_II, DONE.
  - IDLE -> RUN on start_i when cfg_err_o=0. start_i is ignored when cfg_err_o=1. On entry, counter k = iv[k] for all active loops.
  - RUN: iv_valid_o=1.
    - iv_o and iv_last_o are held stable until iv_ready_i=1.
    - On handshake with iv_last_o=1 -> DONE.
    - On handshake otherwise: advance the counters. If effective II is 1, stay in RUN; else -> WAIT_II with ii_cnt = II-1.
  - WAIT_II: iv_valid_o=0; ii_cnt decrements each cycle; -> RUN when ii_cnt reaches 1.
    - Net effect: consecutive handshakes are at least II cycles apart.
  - DONE: done_o=1 for exactly one cycle, then -> IDLE.
- Counter advance (odometer):
  - Loop 0 increments by 1.
  - When loop k equals fv[k], it reloads iv[k] and carries into loop k+1.
  - Only loops < n_loops participate.
  - iv_o for inactive loops is 0.
  - Arithmetic is unsigned NBIT_LP_IV. Equality with fv ends the loop, so no wrap past 2^NBIT_LP_IV-1 can occur.
- iv_last_o = 1 when every active loop equals its fv. This is computed combinationally from the counter registers.
- Single-iteration nest (all iv==fv): the first tuple carries iv_last_o=1.
- stop_i:
  - In any non-IDLE state, next state is IDLE, iv_valid_o drops next cycle, and no done_o pulse is produced.
  - stop_i has priority over a same-cycle handshake and over a same-cycle start_i.
- start_i while busy: ignored.
- Latency: first iv_valid_o appears the cycle after start_i.
- Throughput: one tuple per cycle at II≤1 with ready held high.
- Total tuples emitted = product over active loops of (fv-iv+1).
- Asynchronous reset mid-operation: immediate return to reset values, with no done_o pulse.

Decomposition:
- The following constants and types already live in mage_pkg and are imported: N_LP, LOG2_N_LP, NBIT_LP_IV, NBIT_II, loop_vars_t.
- New package additions:
  - hwlp_state_t enum {IDLE, RUN, WAIT_II, DONE}.
  - hwlp_cfg_t struct {loop_vars_t [N_LP] lv; n_loops; ii}.
- One natural sub-module: mage_hwlp_lp_cnt.
  - A single loop counter with load, enable and carry-in, producing value and at_final.
  - Instantiated N_LP times and chained through carry.

Test Plan:
- n_loops=2, loop0 iv=0 fv=2, loop1 iv=1 fv=2, II=1, ready=1 -> 6 consecutive tuples (0,1),(1,1),(2,1),(0,2),(1,2),(2,2); iv_last_o on the 6th; done_o one cycle later.
- Same config with II=3 -> handshakes exactly 3 cycles apart; 6 tuples over 16 cycles; iv_valid_o low during gaps.
- II=1, ready toggled 1,0,0,1 -> iv_o held stable while ready=0; no tuple skipped or duplicated; sequence matches scenario 1.
- Loop0 iv=5 fv=3 written -> cfg_err_o=1; start_i pulse -> busy_o stays 0, no valid. Rewrite with fv=7 -> cfg_err_o=0.
- stop_i on the 3rd tuple's cycle with ready=1 -> tuple not counted, IDLE next cycle, no done_o. Restart -> sequence restarts at (0,1).
- rst_n_i driven low mid-RUN for one cycle -> outputs 0 asynchronously, config cleared, cfg_we_i required before the next start.

Source files
------------

// File: rtl/mage_hwlp_iv_gen_pkg.sv
// Shared constants and types for the MAGE hardware-loop iteration-variable generator.
// Loop nest geometry, per-loop bounds and the latched configuration payload.
package mage_hwlp_iv_gen_pkg;

    localparam int unsigned N_LP       = 4;
    localparam int unsigned LOG2_N_LP  = $clog2(N_LP);
    localparam int unsigned NBIT_LP_IV = 8;
    localparam int unsigned NBIT_II    = 4;
    localparam int unsigned NBIT_NLP   = LOG2_N_LP + 1;

    typedef struct packed {
        logic [NBIT_LP_IV-1:0] iv;
        logic [NBIT_LP_IV-1:0] fv;
    } loop_vars_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        WAIT_II = 2'd2,
        DONE    = 2'd3
    } hwlp_state_t;

    typedef struct packed {
        loop_vars_t [N_LP-1:0] lv;
        logic [NBIT_NLP-1:0]   n_loops;
        logic [NBIT_II-1:0]    ii;
    } hwlp_cfg_t;

    // An II of 0 behaves like 1, so only values above 1 insert gap cycles.
    function automatic logic ii_needs_gap(input logic [NBIT_II-1:0] ii);
        return ii > NBIT_II'(1);
    endfunction

endpackage

// File: rtl/mage_hwlp_iv_gen_lp_cnt.sv
// One odometer digit of the loop nest: loads its initial value, steps on carry-in,
// and reloads its initial value after reaching its final value.
module mage_hwlp_iv_gen_lp_cnt
    import mage_hwlp_iv_gen_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_load,
    input  logic [NBIT_LP_IV-1:0] i_load_val,
    input  logic                  i_en,
    input  logic                  i_carry,
    input  logic [NBIT_LP_IV-1:0] i_fv,
    output logic [NBIT_LP_IV-1:0] o_val,
    output logic                  o_at_final
);

    logic [NBIT_LP_IV-1:0] r_val;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_val <= '0;
        end else if (i_load) begin
            r_val <= i_load_val;
        end else if (i_en && i_carry) begin
            r_val <= (r_val == i_fv) ? i_load_val : r_val + NBIT_LP_IV'(1);
        end
    end

    assign o_val      = r_val;
    assign o_at_final = (r_val == i_fv);

endmodule

// File: rtl/mage_hwlp_iv_gen.sv
// Hardware-loop iteration-variable generator: walks a perfect loop nest and streams
// one iteration tuple per initiation interval over a valid/ready handshake.
module mage_hwlp_iv_gen
    import mage_hwlp_iv_gen_pkg::*;
(
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic                                  cfg_we_i,
    input  loop_vars_t [N_LP-1:0]                 cfg_loop_vars_i,
    input  logic [NBIT_NLP-1:0]                   cfg_n_loops_i,
    input  logic [NBIT_II-1:0]                    cfg_ii_i,
    input  logic                                  start_i,
    input  logic                                  stop_i,
    output logic [N_LP-1:0][NBIT_LP_IV-1:0]       iv_o,
    output logic                                  iv_valid_o,
    input  logic                                  iv_ready_i,
    output logic                                  iv_last_o,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  cfg_err_o
);

    hwlp_state_t          r_state;
    hwlp_state_t          w_state_nxt;
    hwlp_cfg_t            r_cfg;
    logic                 r_cfg_vld;
    logic                 r_cfg_err;
    logic [NBIT_II-1:0]   r_ii_cnt;
    logic [NBIT_II-1:0]   w_ii_cnt_nxt;
    logic                 w_load;
    logic                 w_adv;
    logic                 w_new_err;
    logic                 w_all_final;
    logic [N_LP-1:0]      w_active;
    logic [N_LP-1:0]      w_at_final;
    logic [N_LP-1:0]      w_carry;

    // Validate the incoming configuration so the error flag tracks each accepted write.
    always_comb begin
        w_new_err = (cfg_n_loops_i == '0) || (cfg_n_loops_i > NBIT_NLP'(N_LP));
        for (int k = 0; k < N_LP; k++) begin
            if ((NBIT_NLP'(k) < cfg_n_loops_i) &&
                (cfg_loop_vars_i[k].fv < cfg_loop_vars_i[k].iv)) begin
                w_new_err = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cfg     <= '0;
            r_cfg_vld <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (cfg_we_i && (r_state == IDLE)) begin
            r_cfg.lv      <= cfg_loop_vars_i;
            r_cfg.n_loops <= cfg_n_loops_i;
            r_cfg.ii      <= cfg_ii_i;
            r_cfg_vld     <= 1'b1;
            r_cfg_err     <= w_new_err;
        end
    end

    // Carry ripples from the innermost loop outward through active loops only.
    always_comb begin
        w_carry     = '0;
        w_carry[0]  = w_adv;
        w_all_final = 1'b1;
        for (int k = 0; k < N_LP; k++) begin
            w_active[k] = NBIT_NLP'(k) < r_cfg.n_loops;
            if (w_active[k] && !w_at_final[k]) begin
                w_all_final = 1'b0;
            end
        end
        for (int k = 1; k < N_LP; k++) begin
            w_carry[k] = w_carry[k-1] & w_active[k-1] & w_at_final[k-1];
        end
    end

    for (genvar g = 0; g < N_LP; g++) begin : g_cnt
        mage_hwlp_iv_gen_lp_cnt u_cnt (
            .clk_i      (clk_i),
            .rst_n_i    (rst_n_i),
            .i_load     (w_load),
            .i_load_val (w_active[g] ? r_cfg.lv[g].iv : NBIT_LP_IV'(0)),
            .i_en       (w_active[g]),
            .i_carry    (w_carry[g]),
            .i_fv       (r_cfg.lv[g].fv),
            .o_val      (iv_o[g]),
            .o_at_final (w_at_final[g])
        );
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state  <= IDLE;
            r_ii_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ii_cnt <= w_ii_cnt_nxt;
        end
    end

    // Next-state logic; stop wins over any same-cycle handshake or start.
    always_comb begin
        w_state_nxt  = r_state;
        w_ii_cnt_nxt = r_ii_cnt;
        w_load       = 1'b0;
        w_adv        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start_i && !stop_i && r_cfg_vld && !r_cfg_err) begin
                    w_state_nxt = RUN;
                    w_load      = 1'b1;
                end
            end
            RUN: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                end else if (iv_ready_i) begin
                    if (w_all_final) begin
                        w_state_nxt = DONE;
                    end else begin
                        w_adv = 1'b1;
                        if (ii_needs_gap(r_cfg.ii)) begin
                            w_state_nxt  = WAIT_II;
                            w_ii_cnt_nxt = r_cfg.ii - NBIT_II'(1);
                        end
                    end
                end
            end
            WAIT_II: begin
                if (stop_i) begin
                    w_state_nxt = IDLE;
                end else if (r_ii_cnt <= NBIT_II'(1)) begin
                    w_state_nxt = RUN;
                end else begin
                    w_ii_cnt_nxt = r_ii_cnt - NBIT_II'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign iv_valid_o = (r_state == RUN);
    assign iv_last_o  = (r_state == RUN) && w_all_final;
    assign busy_o     = (r_state != IDLE);
    assign done_o     = (r_state == DONE);
    assign cfg_err_o  = r_cfg_err;

endmodule

// File: tb/tb_mage_hwlp_iv_gen.sv
// Directed bench for mage_hwlp_iv_gen: sequence order, II spacing, backpressure,
// configuration errors, stop and asynchronous reset.
module tb_mage_hwlp_iv_gen;
    import mage_hwlp_iv_gen_pkg::*;

    typedef logic [N_LP-1:0][NBIT_LP_IV-1:0] iv_vec_t;

    logic                  clk_i = 1'b0;
    logic                  rst_n_i;
    logic                  cfg_we_i;
    loop_vars_t [N_LP-1:0] cfg_loop_vars_i;
    logic [NBIT_NLP-1:0]   cfg_n_loops_i;
    logic [NBIT_II-1:0]    cfg_ii_i;
    logic                  start_i;
    logic                  stop_i;
    iv_vec_t               iv_o;
    logic                  iv_valid_o;
    logic                  iv_ready_i;
    logic                  iv_last_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  cfg_err_o;

    int errors = 0;
    int checks = 0;

    mage_hwlp_iv_gen dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .cfg_we_i        (cfg_we_i),
        .cfg_loop_vars_i (cfg_loop_vars_i),
        .cfg_n_loops_i   (cfg_n_loops_i),
        .cfg_ii_i        (cfg_ii_i),
        .start_i         (start_i),
        .stop_i          (stop_i),
        .iv_o            (iv_o),
        .iv_valid_o      (iv_valid_o),
        .iv_ready_i      (iv_ready_i),
        .iv_last_o       (iv_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .cfg_err_o       (cfg_err_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference tuple i of the 2-loop nest (loop0 0..2, loop1 1..2); loops 2,3 read 0.
    function automatic iv_vec_t exp_tup(input int i);
        iv_vec_t v;
        v    = '0;
        v[0] = NBIT_LP_IV'(i % 3);
        v[1] = NBIT_LP_IV'(1 + i / 3);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_cfg(input logic [7:0] iv0, input logic [7:0] fv0,
                             input logic [7:0] iv1, input logic [7:0] fv1,
                             input logic [NBIT_NLP-1:0] n, input logic [NBIT_II-1:0] ii);
        cfg_loop_vars_i[0].iv = iv0;
        cfg_loop_vars_i[0].fv = fv0;
        cfg_loop_vars_i[1].iv = iv1;
        cfg_loop_vars_i[1].fv = fv1;
        cfg_loop_vars_i[2].iv = 8'd3;
        cfg_loop_vars_i[2].fv = 8'd9;
        cfg_loop_vars_i[3].iv = 8'd3;
        cfg_loop_vars_i[3].fv = 8'd9;
        cfg_n_loops_i = n;
        cfg_ii_i      = ii;
        cfg_we_i      = 1'b1;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({iv_valid_o, busy_o, done_o, cfg_err_o, iv_last_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {iv_valid_o, busy_o, done_o, cfg_err_o, iv_last_o});
        end
        checks++;
        if (iv_o !== iv_vec_t'(0)) begin
            errors++;
            $display("FAIL reset_iv: got %h expected 0", iv_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        iv_ready_i = 1'b1;
        write_cfg(8'd0, 8'd2, 8'd1, 8'd2, 3'd2, 4'd1);
        pulse_start();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (iv_valid_o !== 1'b1 || iv_o !== exp_tup(i) || iv_last_o !== (i == 5)) begin
                errors++;
                $display("FAIL basic_tuple%0d: got v=%b iv=%h last=%b expected v=1 iv=%h last=%b",
                         i, iv_valid_o, iv_o, iv_last_o, exp_tup(i), (i == 5));
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1 || iv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: got done=%b valid=%b expected done=1 valid=0", done_o, iv_valid_o);
        end
        tick();
        checks++;
        if (done_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: got done=%b busy=%b expected 0 0", done_o, busy_o);
        end
    endtask

    task automatic test_ii3();
        iv_ready_i = 1'b1;
        write_cfg(8'd0, 8'd2, 8'd1, 8'd2, 3'd2, 4'd3);
        pulse_start();
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (iv_valid_o !== (c % 3 == 0)) begin
                errors++;
                $display("FAIL ii3_valid_c%0d: got %b expected %b", c, iv_valid_o, (c % 3 == 0));
            end else if (c % 3 == 0 && (iv_o !== exp_tup(c / 3) || iv_last_o !== (c == 15))) begin
                errors++;
                $display("FAIL ii3_tuple_c%0d: got iv=%h last=%b expected iv=%h last=%b",
                         c, iv_o, iv_last_o, exp_tup(c / 3), (c == 15));
            end
            tick();
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL ii3_done: got %b expected 1", done_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   idx = 0;
        int   c   = 0;
        write_cfg(8'd0, 8'd2, 8'd1, 8'd2, 3'd2, 4'd1);
        pulse_start();
        while (idx < 6 && c < 40) begin
            checks++;
            if (iv_valid_o !== 1'b1 || iv_o !== exp_tup(idx) || iv_last_o !== (idx == 5)) begin
                errors++;
                $display("FAIL bp_c%0d: got v=%b iv=%h last=%b expected v=1 iv=%h last=%b",
                         c, iv_valid_o, iv_o, iv_last_o, exp_tup(idx), (idx == 5));
            end
            iv_ready_i = pat[c % 4];
            tick();
            if (pat[c % 4]) idx++;
            c++;
        end
        checks++;
        if (c >= 40) begin
            errors++;
            $display("FAIL bp_timeout: got %0d tuples expected 6", idx);
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: got %b expected 1", done_o);
        end
        iv_ready_i = 1'b1;
        tick();
    endtask

    task automatic test_cfg_err();
        write_cfg(8'd5, 8'd3, 8'd0, 8'd0, 3'd1, 4'd1);
        checks++;
        if (cfg_err_o !== 1'b1) begin
            errors++;
            $display("FAIL cfgerr_fv_lt_iv: got %b expected 1", cfg_err_o);
        end
        pulse_start();
        checks++;
        if (busy_o !== 1'b0 || iv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL cfgerr_start_blocked: got busy=%b valid=%b expected 0 0", busy_o, iv_valid_o);
        end
        write_cfg(8'd5, 8'd7, 8'd0, 8'd0, 3'd1, 4'd1);
        checks++;
        if (cfg_err_o !== 1'b0) begin
            errors++;
            $display("FAIL cfgerr_cleared: got %b expected 0", cfg_err_o);
        end
        write_cfg(8'd0, 8'd1, 8'd0, 8'd1, 3'd5, 4'd1);
        checks++;
        if (cfg_err_o !== 1'b1) begin
            errors++;
            $display("FAIL cfgerr_nloops_big: got %b expected 1", cfg_err_o);
        end
        write_cfg(8'd0, 8'd1, 8'd0, 8'd1, 3'd0, 4'd1);
        checks++;
        if (cfg_err_o !== 1'b1) begin
            errors++;
            $display("FAIL cfgerr_nloops_zero: got %b expected 1", cfg_err_o);
        end
    endtask

    task automatic test_single();
        iv_ready_i = 1'b1;
        write_cfg(8'd4, 8'd4, 8'd0, 8'd0, 3'd1, 4'd0);
        pulse_start();
        checks++;
        if (iv_valid_o !== 1'b1 || iv_o !== iv_vec_t'(4) || iv_last_o !== 1'b1) begin
            errors++;
            $display("FAIL single_tuple: got v=%b iv=%h last=%b expected v=1 iv=%h last=1",
                     iv_valid_o, iv_o, iv_last_o, iv_vec_t'(4));
        end
        tick();
        checks++;
        if (done_o !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got %b expected 1", done_o);
        end
        tick();
    endtask

    task automatic test_stop();
        iv_ready_i = 1'b1;
        write_cfg(8'd0, 8'd2, 8'd1, 8'd2, 3'd2, 4'd1);
        start_i = 1'b1;
        stop_i  = 1'b1;
        tick();
        start_i = 1'b0;
        stop_i  = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_over_start: got busy=%b expected 0", busy_o);
        end
        pulse_start();
        tick();
        tick();
        checks++;
        if (iv_o !== exp_tup(2)) begin
            errors++;
            $display("FAIL stop_third_tuple: got %h expected %h", iv_o, exp_tup(2));
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        checks++;
        if ({busy_o, iv_valid_o, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL stop_idle: got busy/valid/done=%b expected 000", {busy_o, iv_valid_o, done_o});
        end
        tick();
        checks++;
        if (done_o !== 1'b0) begin
            errors++;
            $display("FAIL stop_no_done: got %b expected 0", done_o);
        end
        pulse_start();
        checks++;
        if (iv_valid_o !== 1'b1 || iv_o !== exp_tup(0)) begin
            errors++;
            $display("FAIL stop_restart: got v=%b iv=%h expected v=1 iv=%h", iv_valid_o, iv_o, exp_tup(0));
        end
        tick();
    endtask

    task automatic test_async_reset();
        iv_ready_i = 1'b1;
        #2;
        rst_n_i = 1'b0;
        #1;
        checks++;
        if ({iv_valid_o, busy_o, done_o, cfg_err_o, iv_last_o} !== 5'b0 || iv_o !== iv_vec_t'(0)) begin
            errors++;
            $display("FAIL arst_outputs: got flags=%b iv=%h expected 0 0",
                     {iv_valid_o, busy_o, done_o, cfg_err_o, iv_last_o}, iv_o);
        end
        tick();
        rst_n_i = 1'b1;
        tick();
        pulse_start();
        checks++;
        if (busy_o !== 1'b0 || iv_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL arst_needs_cfg: got busy=%b valid=%b expected 0 0", busy_o, iv_valid_o);
        end
        write_cfg(8'd0, 8'd2, 8'd1, 8'd2, 3'd2, 4'd1);
        pulse_start();
        checks++;
        if (iv_valid_o !== 1'b1 || iv_o !== exp_tup(0)) begin
            errors++;
            $display("FAIL arst_restart: got v=%b iv=%h expected v=1 iv=%h", iv_valid_o, iv_o, exp_tup(0));
        end
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
    endtask

    initial begin
        rst_n_i         = 1'b0;
        cfg_we_i        = 1'b0;
        cfg_loop_vars_i = '0;
        cfg_n_loops_i   = '0;
        cfg_ii_i        = '0;
        start_i         = 1'b0;
        stop_i          = 1'b0;
        iv_ready_i      = 1'b1;
        test_reset();
        test_basic();
        test_ii3();
        test_backpressure();
        test_cfg_err();
        test_single();
        test_stop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
